// File: rtl/cp0_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId, exception and interrupt request.
// Optional same-cycle EPC write bypass on EPCOut: CP0_EPC_BYPASS_EN.
module cp0_ctrl #(
  parameter logic [31:0] PRID = 32'h2023_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        sr_we;
  logic        epc_we;
  logic [31:0] epc_nxt;
  logic [31:0] epc_wdata;

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~exl;
  assign Req     = (int_req | exc_req) & ~reset;

  // A flushed mtc0 never commits.
  assign sr_we  = WE & ~Req & (A == 5'd12);
  assign epc_we = WE & ~Req & (A == 5'd14);

  assign epc_nxt   = (BDIn ? VPC - 32'd4 : VPC) & ~32'd3;
  assign epc_wdata = DIn & ~32'd3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
        bd       <= BDIn;
        epc      <= epc_nxt;
      end else begin
        if (sr_we) begin
          im  <= DIn[15:10];
          exl <= DIn[1];
          ie  <= DIn[0];
        end
        // eret clears EXL after any SR write in the same cycle
        if (EXLClr) exl <= 1'b0;
        if (epc_we) epc <= epc_wdata;
      end
    end
  end

  always_comb begin
    DOut = '0;
    case (A)
      5'd12:   DOut = {16'b0, im, 8'b0, exl, ie};
      5'd13:   DOut = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
      5'd14:   DOut = epc;
      5'd15:   DOut = PRID;
      default: DOut = '0;
    endcase
  end

`ifdef CP0_EPC_BYPASS_EN
  assign EPCOut = epc_we ? epc_wdata : epc;
`else
  assign EPCOut = epc;
`endif

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl with an expected-value queue.
module tb_cp0_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  A = '0;
  logic        WE = 1'b0;
  logic [31:0] DIn = '0;
  logic [31:0] DOut;
  logic [31:0] VPC = '0;
  logic        BDIn = 1'b0;
  logic [4:0]  ExcCodeIn = '0;
  logic [5:0]  HWInt = '0;
  logic        EXLClr = 1'b0;
  logic        Req;
  logic [31:0] EPCOut;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  cp0_ctrl dut (
    .clk(clk), .reset(reset), .A(A), .WE(WE), .DIn(DIn), .DOut(DOut),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    e = exp_q.pop_front();
    total++;
    assert (obs === e.val) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic chk_req(input string tag, input logic want);
    push(tag, {31'b0, want});
    #1;
    check({31'b0, Req});
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a,
                         input logic [31:0] want);
    push(tag, want);
    A = a;
    #1;
    check(DOut);
  endtask

  task automatic chk_epcout(input string tag, input logic [31:0] want);
    push(tag, want);
    #1;
    check(EPCOut);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WE = 1'b1;
    A = a;
    DIn = d;
    step();
    WE = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk_req("rst_req", 1'b0);
    chk_reg("rst_sr", 5'd12, 32'h0);
    chk_reg("rst_cause", 5'd13, 32'h0);
    chk_reg("rst_epc", 5'd14, 32'h0);
    chk_reg("rst_prid", 5'd15, 32'h2023_0007);
    chk_reg("rst_other", 5'd3, 32'h0);
    chk_epcout("rst_epcout", 32'h0);
    #10;
    reset = 1'b0;
    step();

    // exception outside a delay slot
    wr(5'd12, 32'h0000_0401);
    chk_reg("sr_wr", 5'd12, 32'h0000_0401);
    ExcCodeIn = 5'd4;
    VPC = 32'h0000_3008;
    BDIn = 1'b0;
    chk_req("exc_req", 1'b1);
    step();
    ExcCodeIn = 5'd0;
    chk_req("exc_req_drop", 1'b0);
    chk_reg("exc_epc", 5'd14, 32'h0000_3008);
    chk_reg("exc_cause", 5'd13, 32'h0000_0010);
    chk_reg("exc_sr", 5'd12, 32'h0000_0403);
    chk_epcout("exc_epcout", 32'h0000_3008);

    // delay-slot exception
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    chk_reg("eret_sr", 5'd12, 32'h0000_0401);
    ExcCodeIn = 5'd10;
    VPC = 32'h0000_3010;
    BDIn = 1'b1;
    chk_req("bd_req", 1'b1);
    step();
    ExcCodeIn = 5'd0;
    BDIn = 1'b0;
    chk_reg("bd_epc", 5'd14, 32'h0000_300C);
    chk_reg("bd_cause", 5'd13, 32'h8000_0028);

    // interrupt beats exception
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    wr(5'd12, 32'h0000_1001);
    HWInt = 6'b000100;
    ExcCodeIn = 5'd12;
    VPC = 32'h0000_3014;
    chk_req("int_req", 1'b1);
    step();
    ExcCodeIn = 5'd0;
    chk_reg("int_cause", 5'd13, 32'h0000_1000);
    chk_reg("int_epc", 5'd14, 32'h0000_3014);
    chk_req("int_held_exl", 1'b0);

    // no nesting while EXL=1
    ExcCodeIn = 5'd8;
    chk_req("nest_req", 1'b0);
    step();
    ExcCodeIn = 5'd0;
    chk_reg("nest_cause", 5'd13, 32'h0000_1000);
    chk_reg("nest_epc", 5'd14, 32'h0000_3014);
    EXLClr = 1'b1;
    step();
    EXLClr = 1'b0;
    chk_req("pend_int_req", 1'b1);
    HWInt = 6'b0;
    chk_req("int_level_drop", 1'b0);

    // write dropped by flush
    WE = 1'b1;
    A = 5'd14;
    DIn = 32'h0000_5000;
    ExcCodeIn = 5'd4;
    VPC = 32'h0000_3020;
    chk_req("flush_req", 1'b1);
    chk_epcout("flush_epcout", 32'h0000_3014);
    step();
    WE = 1'b0;
    ExcCodeIn = 5'd0;
    chk_reg("flush_epc", 5'd14, 32'h0000_3020);

    // plain EPC write, low bits masked
    WE = 1'b1;
    A = 5'd14;
    DIn = 32'h0000_5003;
`ifdef CP0_EPC_BYPASS_EN
    chk_epcout("byp_epcout", 32'h0000_5000);
`else
    chk_epcout("byp_epcout", 32'h0000_3020);
`endif
    step();
    WE = 1'b0;
    chk_reg("epc_wr", 5'd14, 32'h0000_5000);
    chk_epcout("epc_wr_out", 32'h0000_5000);

    // SR write with EXL=1 and eret together: EXL ends cleared
    EXLClr = 1'b1;
    wr(5'd12, 32'h0000_1003);
    EXLClr = 1'b0;
    chk_reg("sr_eret", 5'd12, 32'h0000_1001);

    // Cause is read-only
    wr(5'd13, 32'hFFFF_FFFF);
    chk_reg("cause_ro", 5'd13, 32'h0000_0010);

    // delay-slot PC wraps
    ExcCodeIn = 5'd4;
    VPC = 32'h0000_0002;
    BDIn = 1'b1;
    chk_req("wrap_req", 1'b1);
    step();
    ExcCodeIn = 5'd0;
    BDIn = 1'b0;
    chk_reg("wrap_epc", 5'd14, 32'hFFFF_FFFC);
    chk_reg("wrap_cause", 5'd13, 32'h8000_0010);

    // async reset mid-cycle with EXL=1
    #1;
    reset = 1'b1;
    ExcCodeIn = 5'd4;
    chk_reg("arst_sr", 5'd12, 32'h0);
    chk_reg("arst_cause", 5'd13, 32'h0);
    chk_reg("arst_epc", 5'd14, 32'h0);
    chk_req("arst_req", 1'b0);
    step();
    reset = 1'b0;
    ExcCodeIn = 5'd0;
    step();

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard leftover=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Coprocessor-0 exception controller for the P7 pipelined MIPS core. Sits beside the M stage, collects the exception code, branch-delay flag and PC carried down the pipeline registers, and merges them with external hardware interrupts. It produces the single `Req` strobe that flushes every pipeline register and redirects fetch to 0x0000_4180. It also holds SR/Cause/EPC/PRId for `mfc0`/`mtc0`/`eret`.

## Interface
- `PRID`, 32'h2023_0007, value returned for register 15.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `A`  in  5  CP0 register number for read and write.
- `WE`  in  1  `mtc0` write enable, M stage.
- `DIn`  in  32  `mtc0` write data.
- `DOut`  out  32  `mfc0` read data, combinational on `A`.
- `VPC`  in  32  PC of the instruction currently in M.
- `BDIn`  in  1  M-stage instruction is in a branch delay slot.
- `ExcCodeIn`  in  5  M-stage exception code; 0 = none.
- `HWInt`  in  6  external interrupt lines, level-sensitive.
- `EXLClr`  in  1  `eret` in M.
- `Req`  out  1  take exception/interrupt this cycle.
- `EPCOut`  out  32  return address for `eret`.

## Operation
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; read-only.
  - EPC(14): [31:2] writable, [1:0] read 0.
  - PRId(15): constant `PRID`.
  - Any other `A` reads 0.
- IntReq = |(HWInt & IM) & IE & !EXL.
- ExcReq = (ExcCodeIn != 0) & !EXL.
- `Req` = IntReq | ExcReq, combinational. Forced 0 while `reset` is high.
- On a clock edge with `Req`=1:
  - EXL <= 1.
  - ExcCode <= IntReq ? 0 : ExcCodeIn. Interrupt has priority over exception.
  - BD <= BDIn.
  - EPC <= (BDIn ? VPC-4 : VPC) & ~3. The subtraction wraps modulo 2^32.
- Cause.IP <= HWInt every cycle, regardless of `Req`.
- `WE` with `Req`=0 writes SR (masked fields) or EPC when `A` = 12 or 14. Writes to other numbers are ignored.
- `WE` with `Req`=1: the write is dropped, because the writing instruction is flushed.
- `EXLClr`=1 clears EXL at the edge. If the same cycle also has an SR write, the SR write lands first and EXL is then cleared.
- `EXLClr` together with `Req` cannot both be effective: the EXL=1 held during `eret` blocks `Req`. If EXL=0, `Req` wins and EXL is set.
- No nesting: while EXL=1, exceptions and interrupts are ignored.

## Timing
- Reset values: SR=0, Cause=0, EPC=0, `Req`=0, `DOut`=0 for A≠15, `EPCOut`=0.
- `Req` asserts in the same cycle the offending instruction is in M. State updates on that cycle's rising edge, the same edge on which the pipeline registers flush.
- `DOut` reflects register contents registered at the previous edge. There is no same-cycle bypass for `DOut`.
- An asynchronous `reset` mid-exception clears EXL and EPC immediately. No `Req` is issued until release.
- An interrupt raised while EXL=1 stays pending in IP and fires on the first cycle after EXL clears, provided IE and IM allow it.

## Configuration
- Macro: `CP0_EPC_BYPASS_EN`.
- Defined: `EPCOut` = DIn & ~3 when `WE` && A==14 && !Req in the same cycle; otherwise the EPC register. This lets `mtc0 EPC` be followed directly by `eret` with no stall.
- Undefined: `EPCOut` is always the EPC register, one cycle of latency after a write. The hazard unit must then stall `eret` behind `mtc0 EPC`.

## Test plan
- Exception, no delay slot:
  - Stimulus: SR=0x0000_0401; ExcCodeIn=4, VPC=0x0000_3008, BDIn=0.
  - Response: `Req`=1 for one cycle. Then EPC=0x0000_3008, Cause.ExcCode=4, EXL=1.
- Delay-slot exception:
  - Stimulus: ExcCodeIn=10, VPC=0x0000_3010, BDIn=1.
  - Response: EPC=0x0000_300C, Cause[31]=1.
- Interrupt priority:
  - Stimulus: IE=1, IM=6'b000100; HWInt=6'b000100 and ExcCodeIn=12 in the same cycle.
  - Response: `Req`=1, ExcCode=0, IP=0x04.
- Nesting blocked:
  - Stimulus: EXL=1; ExcCodeIn=8 asserted.
  - Response: `Req`=0. After `EXLClr` with HWInt still high and enabled, `Req`=1 on the next cycle.
- Write vs flush:
  - Stimulus: WE=1, A=14, DIn=0x0000_5000 in the same cycle as ExcCodeIn=4, VPC=0x0000_3020.
  - Response: EPC=0x0000_3020 (write dropped).
  - With the macro defined and no exception: `EPCOut`=0x0000_5000 in the write cycle.
- Async reset:
  - Stimulus: assert `reset` mid-cycle with EXL=1.
  - Response: SR, Cause, EPC read 0 before the next edge; `Req`=0.
